// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   // Fetch controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HELD  = 2'd2,
      DRAIN = 2'd3
   } if_state_e;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'h0000_0004;

   // Clear the byte-offset bits so every PC is word aligned.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with bubble (highest priority), load and hold.
module ifid_reg
   import if_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [31:0] pc4_i,
   input  logic [31:0] inst_i,
   output logic        valid_o,
   output logic [31:0] pc4_o,
   output logic [31:0] inst_o
);

   logic        valid_q, valid_d;
   logic [31:0] pc4_q,   pc4_d;
   logic [31:0] inst_q,  inst_d;

   // Next-state: a bubble overrides a load; with neither the register holds.
   always_comb begin
      valid_d = valid_q;
      pc4_d   = pc4_q;
      inst_d  = inst_q;
      if (bubble_i) begin
         valid_d = 1'b0;
         pc4_d   = 32'h0000_0000;
         inst_d  = NOP_INST;
      end else if (load_i) begin
         valid_d = 1'b1;
         pc4_d   = pc4_i;
         inst_d  = inst_i;
      end else begin
         valid_d = valid_q;
         pc4_d   = pc4_q;
         inst_d  = inst_q;
      end
   end

   // Register update with asynchronous reset to an empty bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         pc4_q   <= 32'h0000_0000;
         inst_q  <= NOP_INST;
      end else begin
         valid_q <= valid_d;
         pc4_q   <= pc4_d;
         inst_q  <= inst_d;
      end
   end

   assign valid_o = valid_q;
   assign pc4_o   = pc4_q;
   assign inst_o  = inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC ownership, imem handshake, stall buffer and IF/ID.
module if_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_inst_o
);

   if_state_e   state_q,    state_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] pend_q,     pend_d;
   logic [31:0] buf_pc4_q,  buf_pc4_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic        buf_full_q, buf_full_d;

   logic        ifid_load;
   logic        ifid_bubble;
   logic [31:0] ifid_pc4_in;
   logic [31:0] ifid_inst_in;
   logic [31:0] pc_plus4;
   logic [31:0] tgt_aligned;

   assign pc_plus4    = pc_q + PC_STEP;
   assign tgt_aligned = align_word(target_i);

   // Next-state and IF/ID control; flush always takes priority over stall.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      buf_pc4_d    = buf_pc4_q;
      buf_inst_d   = buf_inst_q;
      buf_full_d   = buf_full_q;
      ifid_load    = 1'b0;
      ifid_bubble  = 1'b0;
      ifid_pc4_in  = pc_plus4;
      ifid_inst_in = imem_data_i;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ready_i) begin
               if (flush_i) begin
                  pc_d        = tgt_aligned;
                  ifid_bubble = 1'b1;
               end else if (stall_i) begin
                  buf_pc4_d  = pc_plus4;
                  buf_inst_d = imem_data_i;
                  buf_full_d = 1'b1;
                  pc_d       = pc_plus4;
                  state_d    = HELD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
               end
            end else begin
               if (flush_i) begin
                  pend_d      = tgt_aligned;
                  ifid_bubble = 1'b1;
                  state_d     = DRAIN;
               end else if (stall_i) begin
                  ifid_bubble = 1'b0;
               end else begin
                  ifid_bubble = 1'b1;
               end
            end
         end
         HELD: begin
            if (flush_i) begin
               buf_full_d  = 1'b0;
               pc_d        = tgt_aligned;
               ifid_bubble = 1'b1;
               state_d     = FETCH;
            end else if (!stall_i) begin
               ifid_load    = 1'b1;
               ifid_pc4_in  = buf_pc4_q;
               ifid_inst_in = buf_inst_q;
               buf_full_d   = 1'b0;
               state_d      = FETCH;
            end else begin
               state_d = HELD;
            end
         end
         DRAIN: begin
            // The outstanding request must complete; its data is thrown away.
            if (flush_i) begin
               pend_d = tgt_aligned;
            end else begin
               pend_d = pend_q;
            end
            if (!stall_i) begin
               ifid_bubble = 1'b1;
            end else begin
               ifid_bubble = 1'b0;
            end
            if (imem_ready_i) begin
               pc_d    = flush_i ? tgt_aligned : pend_q;
               state_d = FETCH;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller state, PC, pending redirect and stall buffer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         pend_q     <= RESET_PC;
         buf_pc4_q  <= 32'h0000_0000;
         buf_inst_q <= NOP_INST;
         buf_full_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         buf_pc4_q  <= buf_pc4_d;
         buf_inst_q <= buf_inst_d;
         buf_full_q <= buf_full_d;
      end
   end

   // The PC only moves when a request completes, so during DRAIN it still
   // holds the address of the outstanding request.
   assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;

   ifid_reg u_ifid_reg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (ifid_load),
      .bubble_i (ifid_bubble),
      .pc4_i    (ifid_pc4_in),
      .inst_i   (ifid_inst_in),
      .valid_o  (ifid_valid_o),
      .pc4_o    (ifid_pc4_o),
      .inst_o   (ifid_inst_o)
   );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus queues expected post-edge outputs,
// a monitor pops and compares after every clock edge and every reset edge.
module tb_if_stage;
   import if_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [31:0] pc;
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] target_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_data_i;
   logic [31:0] pc_o;
   logic        ifid_valid_o;
   logic [31:0] ifid_pc4_o;
   logic [31:0] ifid_inst_o;
   logic        done = 1'b0;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // Memory contents: a distinct, address-derived word for every location.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_data_i = mem_word(imem_addr_o);

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .target_i     (target_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ready_i (imem_ready_i),
      .imem_data_i  (imem_data_i),
      .pc_o         (pc_o),
      .ifid_valid_o (ifid_valid_o),
      .ifid_pc4_o   (ifid_pc4_o),
      .ifid_inst_o  (ifid_inst_o)
   );

   task automatic push_exp(input logic req, input logic [31:0] addr, input logic [31:0] pc,
                           input logic valid, input logic [31:0] pc4);
      exp_t e;
      e.req   = req;
      e.addr  = addr;
      e.pc    = pc;
      e.valid = valid;
      e.pc4   = valid ? pc4 : 32'h0;
      e.inst  = valid ? mem_word(pc4 - 32'd4) : 32'h0;
      exp_q.push_back(e);
   endtask

   // One cycle: drive inputs at the falling edge, queue what the next rising edge must produce.
   task automatic step(input logic rs, input logic st, input logic fl, input logic [31:0] tg,
                       input logic rdy, input logic req, input logic [31:0] addr,
                       input logic [31:0] pc, input logic v, input logic [31:0] pc4);
      @(negedge clk);
      rst_i        = rs;
      stall_i      = st;
      flush_i      = fl;
      target_i     = tg;
      imem_ready_i = rdy;
      push_exp(req, addr, pc, v, pc4);
   endtask

   // Monitor: compare after each clock edge and asynchronously after reset assertion.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk or posedge rst_i);
         #1;
         if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
               failures++;
               $display("FAIL sb_leftover actual=%0d entries required=0", exp_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.req   = imem_req_o;
            a.addr  = imem_addr_o;
            a.pc    = pc_o;
            a.valid = ifid_valid_o;
            a.pc4   = ifid_pc4_o;
            a.inst  = ifid_inst_o;
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL sb[%0d] t=%0t actual req=%0b addr=%h pc=%h v=%0b pc4=%h inst=%h required req=%0b addr=%h pc=%h v=%0b pc4=%h inst=%h",
                        checks, $time, a.req, a.addr, a.pc, a.valid, a.pc4, a.inst,
                        e.req, e.addr, e.pc, e.valid, e.pc4, e.inst);
            end
         end
      end
   end

   // Directed stimulus; every expected value written by hand.
   initial begin
      //    rs    st    fl    target        rdy   req   addr          pc            v     pc4
      // reset held
      step(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, RST_PC,       RST_PC,       1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, RST_PC,       RST_PC,       1'b0, 32'h0);
      // release: IDLE for one cycle, then first request
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h100,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h104,      1'b1, 32'h104);
      // stall two cycles with ready: 0x104 word buffered, no request while HELD
      step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h108,      32'h108,      1'b1, 32'h104);
      step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h108,      32'h108,      1'b1, 32'h104);
      // release: buffered 0x104 word enters IF/ID, then fetch resumes at 0x108
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      32'h108,      1'b1, 32'h108);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10C,      32'h10C,      1'b1, 32'h10C);
      // flush with ready, target low bits cleared
      step(1'b0, 1'b0, 1'b1, 32'h203,      1'b1, 1'b1, 32'h200,      32'h200,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      32'h204,      1'b1, 32'h204);
      // simultaneous stall and flush: flush wins
      step(1'b0, 1'b1, 1'b1, 32'h2F1,      1'b1, 1'b1, 32'h2F0,      32'h2F0,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2F4,      32'h2F4,      1'b1, 32'h2F4);
      // 3-cycle memory, flush in first wait cycle: addr stays until ready
      step(1'b0, 1'b0, 1'b1, 32'h300,      1'b0, 1'b1, 32'h2F4,      32'h2F4,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2F4,      32'h2F4,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      32'h300,      1'b0, 32'h0);
      // wait without flush gives bubble; then a good fetch
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      32'h300,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h304,      32'h304,      1'b1, 32'h304);
      // stall while waiting holds IF/ID; plain wait inserts a bubble
      step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h304,      32'h304,      1'b1, 32'h304);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h304,      32'h304,      1'b0, 32'h0);
      // buffer 0x304, then flush out of HELD drops it
      step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h308,      32'h308,      1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h400,      1'b1, 1'b1, 32'h400,      32'h400,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h404,      32'h404,      1'b1, 32'h404);
      // PC+4 wraps at the top of the address space
      step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        1'b1, 32'h0);
      // DRAIN: second flush overwrites pending target; stall holds the bubble
      step(1'b0, 1'b0, 1'b1, 32'h500,      1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h600,      1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h600,      32'h600,      1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h604,      32'h604,      1'b1, 32'h604);
      // enter DRAIN again, then assert reset mid-cycle
      step(1'b0, 1'b1, 1'b1, 32'h700,      1'b0, 1'b1, 32'h604,      32'h604,      1'b0, 32'h0);
      @(negedge clk);
      push_exp(1'b0, RST_PC, RST_PC, 1'b0, 32'h0);
      #2;
      rst_i = 1'b1;
      #2;
      push_exp(1'b0, RST_PC, RST_PC, 1'b0, 32'h0);
      // release and restart at RESET_PC
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, RST_PC,       RST_PC,       1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h104,      1'b1, 32'h104);
      step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      32'h108,      1'b1, 32'h108);
      @(negedge clk);
      done = 1'b1;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
